// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned STRB_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_streak_ctr.sv
// Saturating data-streak counter and the instruction/data priority decision.
module arb_streak_ctr #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic decide,
  output logic pick_d_c
);

  localparam int unsigned SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;

  // Data wins a tie until it has starved a waiting fetch MAX_STREAK times.
  assign pick_d_c = d_req && (!i_req || (streak_q != STREAK_MAX));

  always_comb begin
    streak_d = streak_q;
    if (decide && (i_req || d_req)) begin
      if (pick_d_c && i_req) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch/load-store) arbiter onto a single memory port, one
// transaction outstanding at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata,
  output logic              err_spurious
);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                i_gnt_d, d_gnt_d, i_rvalid_d, d_rvalid_d, err_d;
  logic [XLEN-1:0]     i_rdata_d, d_rdata_d;
  logic                m_req_d, m_we_d;
  logic [XLEN-1:0]     m_addr_d, m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_d;
  logic                decide_c;
  logic                pick_d_c;

  arb_streak_ctr #(
    .MAX_STREAK (MAX_STREAK)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .d_req    (d_req),
    .decide   (decide_c),
    .pick_d_c (pick_d_c)
  );

  // Next-state and next-output logic; the m_* registers double as the latched command.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata;
    d_rdata_d  = d_rdata;
    m_req_d    = m_req;
    m_we_d     = m_we;
    m_addr_d   = m_addr;
    m_wdata_d  = m_wdata;
    m_wstrb_d  = m_wstrb;
    decide_c   = 1'b0;
    err_d      = m_rvalid && (state_q != ST_WAIT);

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          decide_c = 1'b1;
          state_d  = ST_ISSUE;
          m_req_d  = 1'b1;
          if (pick_d_c) begin
            owner_d   = OWN_D;
            d_gnt_d   = 1'b1;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
          end else begin
            owner_d   = OWN_I;
            i_gnt_d   = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_wstrb_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (m_gnt) begin
          state_d   = ST_WAIT;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          m_addr_d  = '0;
          m_wdata_d = '0;
          m_wstrb_d = '0;
        end
      end
      ST_WAIT: begin
        if (m_rvalid) begin
          state_d = ST_RESP;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = m_rdata;
          end else begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = m_rdata;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      i_gnt        <= 1'b0;
      d_gnt        <= 1'b0;
      i_rvalid     <= 1'b0;
      d_rvalid     <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      m_req        <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_wstrb      <= '0;
      err_spurious <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      i_gnt        <= i_gnt_d;
      d_gnt        <= d_gnt_d;
      i_rvalid     <= i_rvalid_d;
      d_rvalid     <= d_rvalid_d;
      i_rdata      <= i_rdata_d;
      d_rdata      <= d_rdata_d;
      m_req        <= m_req_d;
      m_we         <= m_we_d;
      m_addr       <= m_addr_d;
      m_wdata      <= m_wdata_d;
      m_wstrb      <= m_wstrb_d;
      err_spurious <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions, memory responder, event monitor.
module tb_mem_arbiter;

  localparam int K_IGNT = 0;
  localparam int K_DGNT = 1;
  localparam int K_IRV  = 2;
  localparam int K_DRV  = 3;
  localparam int K_ERR  = 4;

  typedef struct {
    int          kind;
    bit          chk;
    logic [31:0] data;
  } ev_t;

  logic        clk, rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb, m_wstrb;
  logic        m_req, m_we, m_gnt, m_rvalid, err_spurious;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic        mdl_gnt, mdl_rvalid, frc_gnt, frc_rvalid, mem_en;
  logic [31:0] mdl_rdata;
  int          stall_cfg;
  ev_t         exp_q[$];
  int          n_tests, n_fail;
  logic        outs_zero;
  bit          ok;

  assign m_gnt    = mdl_gnt | frc_gnt;
  assign m_rvalid = mdl_rvalid | frc_rvalid;
  assign m_rdata  = mdl_rdata;
  assign outs_zero = ~|{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                        m_req, m_we, m_addr, m_wdata, m_wstrb, err_spurious};

  mem_arbiter #(.XLEN(32), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endfunction

  function automatic void sb_check(input int kind, input logic [31:0] data);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got event %0d data %h, expected no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (e.chk && e.data !== data)) begin
        n_fail++;
        $display("FAIL sb_event: got event %0d data %h, expected event %0d data %h",
                 kind, data, e.kind, e.data);
      end
    end
  endfunction

  function automatic void push(input int kind, input bit chk, input logic [31:0] data);
    exp_q.push_back('{kind, chk, data});
  endfunction

  // which: 0 = i_gnt, 1 = d_gnt, 2 = either
  task automatic wait_gnt(input int which, input int maxc, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if ((which == 0 && i_gnt) || (which == 1 && d_gnt) || (which == 2 && (i_gnt || d_gnt))) begin
        seen = 1'b1;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_gnt%0d: got no grant in %0d cycles, expected a grant", which, maxc);
  endtask

  task automatic idle_wait();
    repeat (6) @(negedge clk);
  endtask

  // Memory responder: optional accept stall, read data one cycle after accept.
  initial begin : mem_model
    int          stall_left;
    logic [31:0] a;
    stall_left = -1;
    a          = '0;
    mdl_gnt    = 1'b0;
    mdl_rvalid = 1'b0;
    mdl_rdata  = '0;
    forever begin
      @(negedge clk);
      mdl_rvalid = 1'b0;
      if (mdl_gnt) begin
        mdl_gnt    = 1'b0;
        mdl_rvalid = 1'b1;
        mdl_rdata  = mem_data(a);
      end else if (mem_en && rst && m_req) begin
        if (stall_left < 0) stall_left = stall_cfg;
        if (stall_left == 0) begin
          mdl_gnt    = 1'b1;
          a          = m_addr;
          stall_left = -1;
        end else begin
          stall_left--;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (i_gnt)        sb_check(K_IGNT, m_addr);
      if (d_gnt)        sb_check(K_DGNT, m_addr);
      if (i_rvalid)     sb_check(K_IRV, i_rdata);
      if (d_rvalid)     sb_check(K_DRV, d_rdata);
      if (err_spurious) sb_check(K_ERR, 32'h0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    n_tests = 0; n_fail = 0;
    rst = 1'b0; mem_en = 1'b1; stall_cfg = 0; frc_gnt = 1'b0; frc_rvalid = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(outs_zero), 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single fetch, memory accepts immediately.
    push(K_IGNT, 1'b1, 32'h40);
    push(K_IRV, 1'b1, 32'h0050_0093);
    i_req = 1'b1; i_addr = 32'h40;
    @(negedge clk);
    check("fetch_gnt_cycle1", 32'(i_gnt), 32'h1);
    check("fetch_mwe", {31'h0, m_we}, 32'h0);
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    check("fetch_rvalid_cycle3", 32'(i_rvalid), 32'h1);
    check("fetch_rdata", i_rdata, 32'h0050_0093);
    idle_wait();

    // Store with 3 stalled accept cycles.
    stall_cfg = 3;
    push(K_DGNT, 1'b1, 32'h100);
    push(K_DRV, 1'b0, 32'h0);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    @(negedge clk);
    check("store_gnt_cycle1", 32'(d_gnt), 32'h1);
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("store_cmd_stable",
            32'({m_req, m_we, m_wstrb} == 6'b11_1111 && m_addr == 32'h100 && m_wdata == 32'hDEAD_BEEF),
            32'h1);
    end
    @(negedge clk);
    check("store_mreq_dropped", 32'(m_req), 32'h0);
    stall_cfg = 0;
    idle_wait();

    // Simultaneous first requests: data first, fetch next.
    push(K_DGNT, 1'b1, 32'h180);
    push(K_DRV, 1'b1, 32'h5A5A_0180);
    push(K_IGNT, 1'b1, 32'h80);
    push(K_IRV, 1'b1, 32'h5A5A_0080);
    i_req = 1'b1; i_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180;
    wait_gnt(1, 20, ok);
    d_req = 1'b0;
    wait_gnt(0, 20, ok);
    i_req = 1'b0;
    idle_wait();

    // Both held: four data grants then one fetch, twice.
    for (int t = 0; t < 10; t++) begin
      if (t == 4 || t == 9) begin
        push(K_IGNT, 1'b1, 32'h200);
        push(K_IRV, 1'b1, 32'h5A5A_0200);
      end else begin
        push(K_DGNT, 1'b1, 32'h300);
        push(K_DRV, 1'b1, 32'h5A5A_0300);
      end
    end
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int t = 0; t < 10; t++) wait_gnt(2, 20, ok);
    i_req = 1'b0; d_req = 1'b0;
    idle_wait();

    // Spurious response in IDLE.
    push(K_ERR, 1'b0, 32'h0);
    frc_rvalid = 1'b1;
    @(negedge clk);
    frc_rvalid = 1'b0;
    check("spurious_err_high", 32'(err_spurious), 32'h1);
    @(negedge clk);
    check("spurious_err_one_cycle", 32'(err_spurious), 32'h0);
    idle_wait();

    // Reset during WAIT, then a late response after release.
    mem_en = 1'b0;
    push(K_DGNT, 1'b1, 32'h220);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h220;
    wait_gnt(1, 20, ok);
    d_req = 1'b0;
    frc_gnt = 1'b1;
    @(negedge clk);
    frc_gnt = 1'b0;
    check("wait_mreq_low", 32'(m_req), 32'h0);
    rst = 1'b0;
    #1;
    check("midtxn_reset_outputs", 32'(outs_zero), 32'h1);
    repeat (2) @(negedge clk);
    check("reset_held_outputs", 32'(outs_zero), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    push(K_ERR, 1'b0, 32'h0);
    frc_rvalid = 1'b1;
    @(negedge clk);
    frc_rvalid = 1'b0;
    check("late_rsp_err", 32'(err_spurious), 32'h1);
    @(negedge clk);
    check("late_rsp_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
    mem_en = 1'b1;

    // Arbiter back in IDLE: a new fetch is granted on the next cycle.
    push(K_IGNT, 1'b1, 32'h44);
    push(K_IRV, 1'b1, 32'h5A5A_0044);
    i_req = 1'b1; i_addr = 32'h44;
    @(negedge clk);
    check("post_reset_gnt", 32'(i_gnt), 32'h1);
    i_req = 1'b0;
    idle_wait();

    for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32: address and data width.
REQ-002 Parameter MAX_STREAK, default 4: maximum consecutive data grants while an instruction request waits.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; rst=0 resets immediately, release is synchronous to clk.
REQ-005 i_req in 1 / i_addr in XLEN: instruction fetch request and word address.
REQ-006 i_gnt out 1 / i_rvalid out 1 / i_rdata out XLEN: fetch accepted pulse, read-data valid pulse, read data.
REQ-007 d_req in 1 / d_we in 1 / d_addr in XLEN / d_wdata in XLEN / d_wstrb in 4: load/store request.
REQ-008 d_gnt out 1 / d_rvalid out 1 / d_rdata out XLEN: data accepted pulse, completion pulse (loads and stores), load data.
REQ-009 m_req out 1 / m_we out 1 / m_addr out XLEN / m_wdata out XLEN / m_wstrb out 4: single memory port command.
REQ-010 m_gnt in 1 / m_rvalid in 1 / m_rdata in XLEN: memory accept, response valid, read data.
REQ-011 err_spurious out 1: one-cycle pulse on an unexpected memory response.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT, RESP; exactly one memory transaction outstanding.
REQ-013 IDLE: with any request, pick the winner, latch the winner's addr/we/wdata/wstrb and the owner, and go to ISSUE on the next edge.
REQ-014 i_gnt/d_gnt are registered, asserted only in the first ISSUE cycle and only to the owner; the requester holds req and fields until gnt, then may drop them.
REQ-015 ISSUE: m_req=1 with the latched fields; when m_gnt=1, go to WAIT; otherwise hold all m_* stable.
REQ-016 WAIT: on m_rvalid=1, capture m_rdata and go to RESP.
REQ-017 RESP: owner's rvalid=1 for exactly one cycle with captured rdata, other rvalid=0, then go to IDLE.
REQ-018 Fetch-only owners get m_we=0 and m_wstrb=0; store completions return d_rvalid with d_rdata undefined.
REQ-019 Minimum latency: req seen in IDLE at cycle 0 -> gnt/m_req cycle 1 -> m_rvalid earliest cycle 2 -> rvalid cycle 3; next IDLE decision at cycle 4.
REQ-020 Priority: when both request, data wins unless streak == MAX_STREAK, in which case instruction wins.
REQ-021 Streak counter: increments on a data grant made while i_req=1, saturating at MAX_STREAK; clears on any instruction grant or on a data grant with i_req=0.
REQ-022 Single requester: grant it regardless of streak.
REQ-023 m_rvalid outside WAIT: ignore it, pulse err_spurious for one cycle, and leave the state unchanged.
REQ-024 m_gnt outside ISSUE: ignore it.
REQ-025 Requests arriving outside IDLE wait; no request is dropped while req is held.

Reset
REQ-026 rst=0 forces IDLE, streak=0, and all outputs 0 (gnt, rvalid, rdata, m_*, err_spurious), including mid-transaction.
REQ-027 A memory response to a transaction aborted by reset is treated per REQ-023.

Structure
REQ-028 A shared package holds the FSM state enum, the owner enum (OWN_I, OWN_D) and the XLEN default.
REQ-029 One sub-module, arb_streak_ctr, holds the saturating streak counter and the priority decision.
REQ-030 Target size: 150-300 lines of RTL.

Verification
REQ-031 Single fetch i_addr=0x40 with memory m_gnt same cycle and m_rvalid next cycle, m_rdata=0x00500093 -> i_gnt cycle 1, i_rvalid cycle 3, i_rdata=0x00500093.
REQ-032 Store d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF, memory stalls m_gnt 3 cycles -> m_* held stable 4 cycles, m_we=1, then d_rvalid pulse.
REQ-033 i_req and d_req both held continuously, MAX_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-034 Simultaneous first requests with streak=0 -> d_gnt first; i_gnt next transaction; neither request lost.
REQ-035 rst=0 during WAIT, then late m_rvalid after release -> all outputs 0 during reset, err_spurious one-cycle pulse, no rvalid, state IDLE.
REQ-036 m_rvalid pulsed in IDLE with no request -> err_spurious=1 for one cycle, no gnt, no rvalid.
